mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Parametrised N-channel arbiter merging core-side memory requesters onto one shared memory port.
- Generalises the fixed two-port split (instruction fetch plus load/store) to NUM_CH requesters, with a selectable priority mode and in-order response routing.
- Sits between the core's memory ports and a single-ported memory model or bus.
- Tracks outstanding requests and returns every response to the channel that issued it.

Parameters:
- NUM_CH, 2, number of requester channels (2..8); channel 0 is fetch by convention.
- ADDR_W, 32, address width.
- DATA_W, 32, data width (multiple of 8).
- MAX_OUTST, 4, maximum accepted but unanswered requests (power of 2, >=2).
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_CH  per-channel request valid.
- req_ready  out  NUM_CH  per-channel request accepted this cycle.
- req_we  in  NUM_CH  1 = write, 0 = read.
- req_addr  in  NUM_CH*ADDR_W  channel i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_CH*DATA_W  write data, packed per channel.
- req_be  in  NUM_CH*DATA_W/8  byte enables, packed per channel.
- rsp_valid  out  NUM_CH  one-hot response strobe.
- rsp_rdata  out  DATA_W  response data, shared by all channels.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_rsp_valid  in  1  memory response (reads and write acks), in request order.
- mem_rdata  in  DATA_W  memory read data.
- rsp_err  out  1  sticky: response arrived with no outstanding request.

Behaviour:
- Reset (rstn low, asynchronous):
  - All outputs are 0.
  - Outstanding-ID FIFO is emptied and the lock is cleared.
  - RR pointer last_grant = NUM_CH-1, so channel 0 has first priority.
- Grant (combinational) when the lock is clear:
  - PRIO_MODE 0: first asserted req_valid searching from last_grant+1 upward, wrapping modulo NUM_CH.
  - PRIO_MODE 1: lowest asserted index.
- mem_req_valid = any granted req_valid AND NOT fifo_full. mem_* fields are muxed from the granted channel.
- Handshake:
  - Accept = mem_req_valid && mem_req_ready. req_ready[g] = accept; all other req_ready bits are 0.
  - On accept: push granted ID to FIFO; last_grant <= g; clear lock.
- Stall lock: if mem_req_valid && !mem_req_ready, set lock and hold the grant index next cycle.
  - The requester must keep req_valid and its fields stable while stalled.
  - If the locked channel drops req_valid, clear the lock and re-arbitrate the same cycle.
- FIFO full (MAX_OUTST entries): mem_req_valid is forced 0. A pop in the same cycle does not unblock the push; issue resumes the next cycle.
- Response path:
  - mem_rsp_valid pops the FIFO head h.
  - rsp_valid <= one-hot(h) and rsp_rdata <= mem_rdata, registered, 1-cycle latency.
  - rsp_valid is 0 on cycles without a response.
- Push and pop in the same cycle (not full): count is unchanged, both operations take effect.
- mem_rsp_valid with FIFO empty: no pop, rsp_valid stays 0, rsp_err <= 1. rsp_err is held until reset.
- Pointers are log2(MAX_OUTST) bits and wrap naturally; count is log2(MAX_OUTST)+1 bits.
- Reset mid-transaction discards outstanding IDs. Responses arriving after reset with the FIFO empty set rsp_err.
- Throughput: one accept per cycle when mem_req_ready is 1 and the FIFO is not full.

Test Plan:
- Reset, then all channels idle:
  - All outputs are 0.
  - Raise req_valid[0] with addr 0x100, mem_req_ready=1 → mem_req_valid=1, mem_addr=0x100, req_ready=2'b01 in the same cycle.
- Round-robin, NUM_CH=2, both channels valid continuously, mem_req_ready=1:
  - Grants alternate ch0, ch1, ch0, ch1.
  - With PRIO_MODE=1 every grant goes to ch0.
- Stall lock:
  - ch1 granted with mem_req_ready=0 for 3 cycles while ch0 raises req_valid.
  - mem_addr stays at the ch1 address and req_ready stays 0.
  - On ready=1, ch1 is accepted; ch0 is granted the next cycle.
- Full FIFO, MAX_OUTST=4:
  - Issue 4 reads with no response → 5th request sees mem_req_valid=0.
  - A single mem_rsp_valid frees one slot; issue resumes one cycle after the pop.
- Response routing:
  - Accept ch1, ch0, ch1 reads; return rdata 0xA, 0xB, 0xC.
  - rsp_valid sequence is 10, 01, 10 with matching rsp_rdata, each one cycle after mem_rsp_valid.
- Spurious response and mid-operation reset:
  - mem_rsp_valid with the FIFO empty → rsp_err=1 and sticky, no rsp_valid.
  - Assert rstn=0 mid-stream with 2 requests outstanding → rsp_err=0, FIFO empty, next grant goes to ch0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// N-channel request arbiter onto a single memory port, with an in-order
// outstanding-ID FIFO that routes each memory response back to its requester.
module mem_port_arbiter #(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4,
    parameter int PRIO_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_CH-1:0]          req_valid,
    output logic [NUM_CH-1:0]          req_ready,
    input  logic [NUM_CH-1:0]          req_we,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
    input  logic [NUM_CH*DATA_W/8-1:0] req_be,
    output logic [NUM_CH-1:0]          rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic [DATA_W/8-1:0]        mem_be,
    input  logic                       mem_rsp_valid,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       rsp_err
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam int CNT_W = PTR_W + 1;
    localparam int BE_W  = DATA_W / 8;

    logic [ADDR_W-1:0] addr_arr  [NUM_CH];
    logic [DATA_W-1:0] wdata_arr [NUM_CH];
    logic [BE_W-1:0]   be_arr    [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
            assign be_arr[gi]    = req_be[gi*BE_W +: BE_W];
        end
    endgenerate

    logic [CH_W-1:0]  last_grant_reg;
    logic [CH_W-1:0]  lock_idx_reg;
    logic             lock_reg;
    logic [CH_W-1:0]  grant;
    logic [CH_W-1:0]  cand;
    logic             grant_any;
    logic [CH_W-1:0]  id_mem [MAX_OUTST];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             fifo_full;
    logic             accept;
    logic             stall;
    logic             pop;

    // Loops run from lowest to highest priority so the last match wins.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        cand      = '0;
        if (lock_reg && req_valid[lock_idx_reg]) begin
            grant     = lock_idx_reg;
            grant_any = 1'b1;
        end else if (PRIO_MODE == 1) begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                if (req_valid[CH_W'(k)]) begin
                    grant     = CH_W'(k);
                    grant_any = 1'b1;
                end
            end
        end else begin
            for (int k = NUM_CH; k >= 1; k--) begin
                cand = CH_W'((int'(last_grant_reg) + k) % NUM_CH);
                if (req_valid[cand]) begin
                    grant     = cand;
                    grant_any = 1'b1;
                end
            end
        end
    end

    assign fifo_full     = (count_reg == CNT_W'(MAX_OUTST));
    assign mem_req_valid = grant_any && !fifo_full;
    assign accept        = mem_req_valid && mem_req_ready;
    assign stall         = mem_req_valid && !mem_req_ready;
    assign req_ready     = accept ? (NUM_CH'(1) << grant) : '0;
    assign pop           = mem_rsp_valid && (count_reg != '0);

    assign mem_we    = grant_any && req_we[grant];
    assign mem_addr  = grant_any ? addr_arr[grant]  : '0;
    assign mem_wdata = grant_any ? wdata_arr[grant] : '0;
    assign mem_be    = grant_any ? be_arr[grant]    : '0;

    always_ff @(posedge clk) begin
        if (accept) begin
            id_mem[wr_ptr_reg] <= grant;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant_reg <= CH_W'(NUM_CH - 1);
            lock_idx_reg   <= '0;
            lock_reg       <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            rsp_valid      <= '0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_reg     <= wr_ptr_reg + 1'b1;
                last_grant_reg <= grant;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                rsp_rdata  <= mem_rdata;
            end
            count_reg <= count_reg + CNT_W'(accept) - CNT_W'(pop);
            // A stalled grant is pinned so fixed priority cannot steal it mid-handshake.
            lock_reg <= stall;
            if (stall) begin
                lock_idx_reg <= grant;
            end
            rsp_valid <= pop ? (NUM_CH'(1) << id_mem[rd_ptr_reg]) : '0;
            if (mem_rsp_valid && (count_reg == '0)) begin
                rsp_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter: a rule-level model predicts
// each cycle's memory request and each routed response; a monitor compares.
module tb_mem_port_arbiter;
    localparam int NCH  = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXO = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [NCH-1:0]    req_valid = '0;
    logic [NCH-1:0]    req_we    = '0;
    logic [NCH*AW-1:0] req_addr  = '0;
    logic [NCH*DW-1:0] req_wdata = '0;
    logic [NCH*BW-1:0] req_be    = '0;
    logic              mem_req_ready = 1'b0;
    logic              mem_rsp_valid = 1'b0;
    logic [DW-1:0]     mem_rdata = '0;

    logic [NCH-1:0] req_ready, rsp_valid;
    logic [DW-1:0]  rsp_rdata, mem_wdata;
    logic           mem_req_valid, mem_we, rsp_err;
    logic [AW-1:0]  mem_addr;
    logic [BW-1:0]  mem_be;

    logic [NCH-1:0] fp_req_ready, fp_rsp_valid;
    logic [DW-1:0]  fp_rsp_rdata, fp_mem_wdata;
    logic           fp_mem_req_valid, fp_mem_we, fp_rsp_err;
    logic [AW-1:0]  fp_mem_addr;
    logic [BW-1:0]  fp_mem_be;

    mem_port_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MAXO), .PRIO_MODE(0)) u_dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .rsp_err(rsp_err)
    );

    mem_port_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MAXO), .PRIO_MODE(1)) u_fp (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(fp_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(fp_rsp_valid),
        .rsp_rdata(fp_rsp_rdata), .mem_req_valid(fp_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(fp_mem_we), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_be(fp_mem_be),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .rsp_err(fp_rsp_err)
    );

    typedef struct packed {
        logic           rst;
        logic           mvalid;
        logic [NCH-1:0] ready;
        logic [AW-1:0]  addr;
        logic           we;
        logic [DW-1:0]  wdata;
        logic [BW-1:0]  be;
        logic           err;
        logic           chk_fp;
        logic [AW-1:0]  fp_addr;
    } cyc_t;

    typedef struct packed {
        logic [NCH-1:0] onehot;
        logic [DW-1:0]  data;
        logic [31:0]    due;
    } rsp_t;

    cyc_t cq[$];
    rsp_t rq[$];
    int   pend[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Requester-side held requests and the model's arbitration state.
    logic [NCH-1:0] hold = '0;
    logic [AW-1:0]  haddr [NCH];
    logic           hwe   [NCH];
    logic [DW-1:0]  hwd   [NCH];
    logic [BW-1:0]  hbe   [NCH];
    int             m_last = NCH - 1;
    bit             m_lock = 0;
    int             m_lock_ch = 0;
    bit             m_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_grant(input logic [NCH-1:0] v);
        if (m_lock && v[m_lock_ch]) return m_lock_ch;
        for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (m_last + k) % NCH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // rdy: 0/1 fixed, 2 random. rsp: 0 none, 1 if pending, 2 random, 3 forced (even if none pending).
    task automatic step(input bit rst, input logic [NCH-1:0] want, input bit rnd, input int rdy,
                        input int rsp, input logic [AW-1:0] faddr, input bit chk_fp);
        cyc_t r;
        rsp_t e;
        int   g, h;
        bit   mv, acc, do_rsp;
        @(posedge clk);
        #1;
        r = '0;
        if (rst) begin
            rstn = 1'b0;
            req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
            mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
            hold = '0; pend.delete(); rq.delete();
            m_lock = 0; m_last = NCH - 1; m_err = 0;
            r.rst = 1'b1;
            cq.push_back(r);
            return;
        end
        rstn = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            if (!hold[c] && (want[c] || (rnd && $urandom_range(0, 1) == 1))) begin
                hold[c]  = 1'b1;
                haddr[c] = (faddr != '0) ? faddr + AW'(c * 4) : ($urandom & 32'hFFFF_FFFC);
                hwe[c]   = 1'($urandom_range(0, 1));
                hwd[c]   = $urandom;
                hbe[c]   = BW'($urandom);
            end
            req_we[c] = hold[c] ? hwe[c] : 1'b0;
            req_addr[c*AW +: AW]  = haddr[c];
            req_wdata[c*DW +: DW] = hwd[c];
            req_be[c*BW +: BW]    = hbe[c];
        end
        req_valid     = hold;
        mem_req_ready = (rdy == 2) ? ($urandom_range(0, 3) != 0) : (rdy != 0);
        do_rsp = (rsp == 3) || (rsp == 1 && pend.size() > 0) ||
                 (rsp == 2 && pend.size() > 0 && $urandom_range(0, 1) == 1);
        mem_rsp_valid = do_rsp;
        mem_rdata     = $urandom;

        g   = model_grant(hold);
        mv  = (g >= 0) && (pend.size() < MAXO);
        acc = mv && mem_req_ready;
        r.mvalid  = mv;
        r.err     = m_err;
        r.chk_fp  = chk_fp;
        r.fp_addr = haddr[0];
        if (g >= 0) begin
            r.addr = haddr[g]; r.we = hwe[g]; r.wdata = hwd[g]; r.be = hbe[g];
        end
        if (acc) r.ready[g] = 1'b1;
        cq.push_back(r);

        if (do_rsp) begin
            if (pend.size() > 0) begin
                h = pend.pop_front();
                e = '0;
                e.onehot[h] = 1'b1;
                e.data = mem_rdata;
                e.due  = 32'(cyc + 2);
                rq.push_back(e);
            end else begin
                m_err = 1;
            end
        end
        if (acc) begin
            m_last = g; m_lock = 0; pend.push_back(g); hold[g] = 1'b0;
        end else if (mv) begin
            m_lock = 1; m_lock_ch = g;
        end else begin
            m_lock = 0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (pend.size() > 0 || hold != '0); i++) step(0, '0, 0, 1, 1, '0, 0);
    endtask

    // Monitor: one expected record per cycle plus the in-order response queue.
    initial begin
        cyc_t r;
        rsp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (cq.size() > 0) begin
                r = cq.pop_front();
                chk("mem_req_valid", 64'(mem_req_valid), 64'(r.mvalid));
                chk("req_ready", 64'(req_ready), 64'(r.ready));
                chk("rsp_err", 64'(rsp_err), 64'(r.err));
                if (r.mvalid) begin
                    chk("mem_addr", 64'(mem_addr), 64'(r.addr));
                    chk("mem_we", 64'(mem_we), 64'(r.we));
                    chk("mem_wdata", 64'(mem_wdata), 64'(r.wdata));
                    chk("mem_be", 64'(mem_be), 64'(r.be));
                end
                if (r.rst) begin
                    chk("reset_mem_fields", {mem_addr, mem_wdata}, 64'h0);
                    chk("reset_mem_we_be", 64'({mem_we, mem_be}), 64'h0);
                end
                if (r.chk_fp) begin
                    chk("fp_req_ready", 64'(fp_req_ready), 64'h1);
                    chk("fp_mem_addr", 64'(fp_mem_addr), 64'(r.fp_addr));
                end
            end
            if (rsp_valid !== '0) begin
                if (rq.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'h0);
                end else begin
                    e = rq.pop_front();
                    chk("rsp_valid", 64'(rsp_valid), 64'(e.onehot));
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
                    chk("rsp_latency", 64'(cyc), 64'(e.due));
                end
            end else if (rq.size() > 0 && int'(rq[0].due) <= cyc) begin
                e = rq.pop_front();
                chk("rsp_missing", 64'(rsp_valid), 64'(e.onehot));
            end
        end
    end

    initial begin
        repeat (3) step(1, '0, 0, 0, 0, '0, 0);
        step(0, 2'b01, 0, 1, 0, 32'h100, 0);
        repeat (2) step(1, '0, 0, 0, 0, '0, 0);
        // Both channels continuously valid: alternating grants, then the FIFO fills.
        repeat (4) step(0, 2'b11, 0, 1, 0, 32'h200, 1);
        step(0, 2'b11, 0, 1, 0, 32'h200, 0);
        step(0, 2'b11, 0, 1, 1, 32'h200, 0);
        step(0, 2'b11, 0, 1, 0, 32'h200, 0);
        drain();
        // Stall with ch1 granted while ch0 arrives.
        step(0, 2'b10, 0, 0, 0, 32'h300, 0);
        repeat (3) step(0, 2'b11, 0, 0, 0, 32'h300, 0);
        repeat (2) step(0, '0, 0, 1, 0, '0, 0);
        drain();
        // Response routing ch1, ch0, ch1.
        step(0, 2'b10, 0, 1, 0, 32'h400, 0);
        step(0, 2'b01, 0, 1, 0, 32'h400, 0);
        step(0, 2'b10, 0, 1, 0, 32'h400, 0);
        repeat (3) step(0, '0, 0, 1, 1, '0, 0);
        drain();
        // Spurious response: sticky error.
        step(0, '0, 0, 1, 3, '0, 0);
        repeat (3) step(0, '0, 0, 1, 0, '0, 0);
        repeat (1500) step(0, '0, 1, 2, 2, '0, 0);
        drain();
        // Reset with two requests outstanding.
        repeat (2) step(0, 2'b11, 0, 1, 0, 32'h500, 0);
        repeat (2) step(1, '0, 0, 0, 0, '0, 0);
        step(0, 2'b11, 0, 1, 0, 32'h600, 0);
        drain();
        step(0, '0, 0, 1, 3, '0, 0);
        repeat (3) step(0, '0, 0, 1, 0, '0, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rsp_queue_empty", 64'(rq.size()), 64'h0);
        chk("cycle_queue_empty", 64'(cq.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
